lsu_pipe: RTL and testbench
===========================

// Module: lsu_pipe
// PURPOSE
//  Pipelined load/store unit between the ALU stage and the data-memory port. Accepts one op per
//  cycle over a valid/ready handshake, issues aligned memory requests with byte strobes, keeps up
//  to OUTSTANDING loads in flight, and aligns/sign-extends load data in-block. Traps misaligned
//  accesses. Writeback leaves in program order.
// PARAMETERS
//  OUTSTANDING  2  max loads issued but not yet responded (>=1)
//  ADDR_W      32  byte-address width
//  TRAP_MISAL   1  1: flag misaligned word/half; 0: force address down to natural alignment
// PORTS
//  CLK            in   1       clock, all state on posedge
//  RST            in   1       asynchronous, active-high reset
//  req_vld        in   1       op valid from ALU stage
//  req_rdy        out  1       op accepted when req_vld & req_rdy
//  req_op         in   4       [3]=mem op, [2]=store, [1:0]=size 11 word/10 half/01 byte
//  req_lsign      in   1       load: 1 = sign-extend, 0 = zero-extend
//  req_addr       in   ADDR_W  byte address (mem op) or ALU result (non-mem op)
//  req_wdata      in   32      store data, right-aligned
//  req_rd         in   5       destination register
//  req_rd_wen     in   1       destination write enable
//  wb_vld         out  1       writeback valid, one-cycle pulse
//  wb_rd          out  5       writeback register
//  wb_wen         out  1       writeback enable
//  wb_data        out  32      writeback data
//  misal_vld      out  1       misaligned-access pulse
//  misal_addr     out  ADDR_W  faulting address
//  rsp_err        out  1       sticky: response received with no load outstanding
//  mem_req_vld    out  1       memory request valid
//  mem_req_rdy    in   1       memory accepts request
//  mem_we         out  4       byte write strobes (0000 = read)
//  mem_addr       out  ADDR_W  word-aligned address
//  mem_wdata      out  32      lane-placed store data
//  mem_rsp_vld    in   1       read response valid (in order, >=1 cycle after request)
//  mem_rdata      in   32      read data, full word
// BEHAVIOUR
//  Reset: req_rdy per formula below; wb_vld/wb_wen/misal_vld/rsp_err=0; wb_rd/wb_data/misal_addr=0;
//   tracker empty (count=0). Responses after reset to pre-reset loads raise rsp_err.
//  Classes: non-mem op (req_op[3]=0), store, load, misaligned (word addr[1:0]!=0 or half addr[0]!=0,
//   TRAP_MISAL=1 only).
//  req_rdy: non-mem = tracker empty; misaligned = 1; store = mem_req_rdy; load = mem_req_rdy & ~full.
//   A pop in the same cycle does not relieve full.
//  mem_req_vld = req_vld & mem op & ~misaligned & (store | ~full); independent of mem_req_rdy.
//  mem_addr = {addr[ADDR_W-1:2],2'b00}. Store strobes/data: word 1111; half addr[1]? 1100:0011 with
//   data {h,h}; byte 0001<<addr[1:0] with data {b,b,b,b}. Load: mem_we=0.
//  Load accept pushes {rd, rd_wen, lsign, size, addr[1:0]} into tracker; mem_rsp_vld pops head.
//   Push+pop same cycle: count unchanged. Count is $clog2(OUTSTANDING+1) bits.
//  Load writeback: registered, wb_vld 1 cycle after mem_rsp_vld. Byte lane = addr[1:0],
//   half lane = addr[1]; extend per lsign to 32 b.
//  Non-mem writeback: wb_vld 1 cycle after accept, wb_data=req_addr. Store: no writeback.
//  Misaligned: consumed, no mem request, no writeback; misal_vld/misal_addr registered, 1-cycle pulse.
//  mem_rsp_vld with tracker empty: ignored, rsp_err set until RST.
//  Ordering: non-mem ops wait for an empty tracker, so wb from loads and non-mem ops never collide.
// STRUCTURE
//  lsu_pkg: size encodings (LS_WORD/HALF/BYTE), req_op bit indices, tracker entry struct.
//  Sub-module lsu_load_tracker: sync FIFO, depth OUTSTANDING, push/pop/full/empty/count.
//  Top: accept/issue logic, store lane placement, load extract/extend, wb/misal registers.
// TESTING
//  LW 0x100, rdata 0xDEADBEEF next cycle -> wb_vld 1 cycle later, wb_data 0xDEADBEEF.
//  LB lsign=1 addr 0x103, rdata 0x80000000 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x102 wdata 0x1234 -> mem_we 1100, mem_addr 0x100, mem_wdata 0x12341234, no wb.
//  OUTSTANDING=2, three back-to-back LW, no response -> third held, req_rdy=0 until first rsp.
//  LW addr 0x101 (TRAP_MISAL=1) -> misal_vld pulse, misal_addr 0x101, no mem_req_vld, no wb.
//  Two LW in flight, RST asserted -> outputs zero at once; later mem_rsp_vld -> rsp_err=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//   - ls_size_e   : access-size encoding carried in req_op[1:0]
//   - OP_*_BIT    : bit positions inside req_op
//   - ld_entry_t  : per-load bookkeeping held while a read is outstanding
//   - store_strobe / load_extract : lane helpers used by the pipeline top
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    LS_RSVD = 2'b00,
    LS_BYTE = 2'b01,
    LS_HALF = 2'b10,
    LS_WORD = 2'b11
  } ls_size_e;

  localparam int unsigned OP_MEM_BIT   = 3;
  localparam int unsigned OP_STORE_BIT = 2;

  // Everything needed to turn a raw memory word into a writeback once the
  // response arrives; the request itself is long gone by then.
  typedef struct packed {
    logic [4:0] rd;
    logic       rd_wen;
    logic       lsign;
    ls_size_e   size;
    logic [1:0] lane;
  } ld_entry_t;

  // Byte write strobes for an (already aligned) store.
  function automatic logic [3:0] store_strobe(input ls_size_e size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      LS_WORD: strb = 4'b1111;
      LS_HALF: strb = lane[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b0001 << lane;
    endcase
    return strb;
  endfunction

  // Pick the addressed lane out of a full read word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input ls_size_e size, input logic lsign,
                                               input logic [1:0] lane, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      LS_WORD: r = rdata;
      LS_HALF: r = {{16{lsign & h[15]}}, h};
      default: r = {{24{lsign & b[7]}}, b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_tracker.sv
// -----------------------------------------------------------------------------
// lsu_load_tracker
//   Synchronous FIFO of ld_entry_t, one entry per load issued but not yet
//   answered. Memory answers in order, so the head is always the load that the
//   next response belongs to.
// Ports
//   clk, rst      clock / asynchronous active-high reset
//   push_i        enqueue push_data_i (ignored when full)
//   push_data_i   entry for the load just issued
//   pop_i         dequeue head (ignored when empty)
//   head_o        entry at the head of the queue
//   full_o        DEPTH entries held
//   empty_o       no entries held
//   count_o       number of entries held
// -----------------------------------------------------------------------------
module lsu_load_tracker
  import lsu_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  ld_entry_t        push_data_i,
  input  logic             pop_i,
  output ld_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ld_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry storage has no reset; count_q guards every read, so stale
  // contents are never observed and the array can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/lsu_pipe.sv
// -----------------------------------------------------------------------------
// lsu_pipe
//   Load/store unit between the ALU stage and the data-memory port. One op per
//   cycle over valid/ready; stores and loads go straight to memory as aligned
//   word requests with byte strobes, loads are remembered in lsu_load_tracker
//   until their in-order response comes back, then aligned/extended and
//   written back. Non-memory ops write their ALU result back but only once no
//   load is outstanding, which keeps writeback in program order.
// Ports
//   clk, rst                  clock / asynchronous active-high reset
//   req_vld_i / req_rdy_o     op handshake from the ALU stage
//   req_op_i                  [3]=mem op, [2]=store, [1:0]=size
//   req_lsign_i               load sign-extend select
//   req_addr_i                byte address (mem op) or ALU result
//   req_wdata_i               right-aligned store data
//   req_rd_i / req_rd_wen_i   destination register / enable
//   wb_vld_o/wb_rd_o/wb_wen_o/wb_data_o   registered writeback
//   misal_vld_o / misal_addr_o            registered misaligned-access pulse
//   rsp_err_o                 sticky: response arrived with nothing outstanding
//   mem_req_vld_o / mem_req_rdy_i, mem_we_o, mem_addr_o, mem_wdata_o
//                             memory request channel
//   mem_rsp_vld_i / mem_rdata_i           in-order read response
// -----------------------------------------------------------------------------
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          TRAP_MISAL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld_i,
  output logic              req_rdy_o,
  input  logic [3:0]        req_op_i,
  input  logic              req_lsign_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_i,
  input  logic              req_rd_wen_i,
  output logic              wb_vld_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_wen_o,
  output logic [31:0]       wb_data_o,
  output logic              misal_vld_o,
  output logic [ADDR_W-1:0] misal_addr_o,
  output logic              rsp_err_o,
  output logic              mem_req_vld_o,
  input  logic              mem_req_rdy_i,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_rsp_vld_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic       is_mem, is_store, misal;
  ls_size_e   size;
  logic [1:0] lane;

  assign is_mem   = req_op_i[OP_MEM_BIT];
  assign is_store = req_op_i[OP_STORE_BIT];
  assign size     = ls_size_e'(req_op_i[1:0]);

  // lane is the byte offset actually used for strobes and load extraction.
  // With trapping disabled a misaligned word/half is pulled down to its
  // natural boundary instead of being flagged.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    misal = 1'b0;
    lane  = req_addr_i[1:0];
    case (size)
      LS_WORD: begin
        misal = TRAP_MISAL && is_mem && (req_addr_i[1:0] != 2'b00);
        lane  = 2'b00;
      end
      LS_HALF: begin
        misal = TRAP_MISAL && is_mem && req_addr_i[0];
        lane  = {req_addr_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load tracker
  // ---------------------------------------------------------------------------
  ld_entry_t        push_entry, head;
  logic             ld_push, ld_pop, ld_full, ld_empty;
  logic [CNT_W-1:0] ld_count;
  logic             accept;

  assign push_entry = '{rd: req_rd_i, rd_wen: req_rd_wen_i, lsign: req_lsign_i,
                        size: size, lane: lane};

  lsu_load_tracker #(
    .DEPTH (OUTSTANDING)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ld_push),
    .push_data_i (push_entry),
    .pop_i       (ld_pop),
    .head_o      (head),
    .full_o      (ld_full),
    .empty_o     (ld_empty),
    .count_o     (ld_count)
  );

  // ---------------------------------------------------------------------------
  // Handshake and memory request
  // ---------------------------------------------------------------------------
  // full is the registered state; a response popping this cycle does not free
  // a slot for a load accepted in the same cycle.
  always_comb begin
    if (!is_mem)       req_rdy_o = (ld_count == '0);
    else if (misal)    req_rdy_o = 1'b1;
    else if (is_store) req_rdy_o = mem_req_rdy_i;
    else               req_rdy_o = mem_req_rdy_i & ~ld_full;
  end

  assign mem_req_vld_o = req_vld_i & is_mem & ~misal & (is_store | ~ld_full);
  assign accept        = req_vld_i & req_rdy_o;
  assign ld_push       = accept & is_mem & ~is_store & ~misal;
  assign ld_pop        = mem_rsp_vld_i & ~ld_empty;

  assign mem_addr_o = {req_addr_i[ADDR_W-1:2], 2'b00};
  assign mem_we_o   = (is_mem && is_store) ? store_strobe(size, lane) : 4'b0000;

  // Data is replicated into every lane; the strobes select which bytes land.
  always_comb begin
    case (size)
      LS_WORD: mem_wdata_o = req_wdata_i;
      LS_HALF: mem_wdata_o = {2{req_wdata_i[15:0]}};
      default: mem_wdata_o = {4{req_wdata_i[7:0]}};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback / misaligned / error registers
  // ---------------------------------------------------------------------------
  logic              wb_vld_q, wb_vld_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_wen_q, wb_wen_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              misal_vld_q, misal_vld_d;
  logic [ADDR_W-1:0] misal_addr_q, misal_addr_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       load_data;

  assign load_data = load_extract(head.size, head.lsign, head.lane, mem_rdata_i);

  // A pop and a non-mem accept cannot coincide: pop needs a non-empty tracker,
  // non-mem accept needs an empty one.
  always_comb begin
    wb_vld_d     = 1'b0;
    wb_wen_d     = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    if (ld_pop) begin
      wb_vld_d  = 1'b1;
      wb_rd_d   = head.rd;
      wb_wen_d  = head.rd_wen;
      wb_data_d = load_data;
    end else if (accept && !is_mem) begin
      wb_vld_d  = 1'b1;
      wb_rd_d   = req_rd_i;
      wb_wen_d  = req_rd_wen_i;
      wb_data_d = 32'(req_addr_i);
    end
    misal_vld_d  = accept & misal;
    misal_addr_d = misal_vld_d ? req_addr_i : misal_addr_q;
    rsp_err_d    = rsp_err_q | (mem_rsp_vld_i & ld_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld_q     <= 1'b0;
      wb_rd_q      <= '0;
      wb_wen_q     <= 1'b0;
      wb_data_q    <= '0;
      misal_vld_q  <= 1'b0;
      misal_addr_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      wb_vld_q     <= wb_vld_d;
      wb_rd_q      <= wb_rd_d;
      wb_wen_q     <= wb_wen_d;
      wb_data_q    <= wb_data_d;
      misal_vld_q  <= misal_vld_d;
      misal_addr_q <= misal_addr_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign wb_vld_o     = wb_vld_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_wen_o     = wb_wen_q;
  assign wb_data_o    = wb_data_q;
  assign misal_vld_o  = misal_vld_q;
  assign misal_addr_o = misal_addr_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;

  localparam int OUT = 2;

  localparam logic [3:0] ALU = 4'b0000;
  localparam logic [3:0] LW  = 4'b1011;
  localparam logic [3:0] LH  = 4'b1010;
  localparam logic [3:0] LB  = 4'b1001;
  localparam logic [3:0] SW  = 4'b1111;
  localparam logic [3:0] SH  = 4'b1110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_vld, req_rdy, req_lsign, req_rd_wen;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        wb_vld, wb_wen, misal_vld, rsp_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, misal_addr;
  logic        mem_req_vld, mem_req_rdy, mem_rsp_vld;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  lsu_pipe #(.OUTSTANDING(OUT), .ADDR_W(32), .TRAP_MISAL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_op_i(req_op), .req_lsign_i(req_lsign),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd), .req_rd_wen_i(req_rd_wen),
    .wb_vld_o(wb_vld), .wb_rd_o(wb_rd), .wb_wen_o(wb_wen), .wb_data_o(wb_data),
    .misal_vld_o(misal_vld), .misal_addr_o(misal_addr), .rsp_err_o(rsp_err),
    .mem_req_vld_o(mem_req_vld), .mem_req_rdy_i(mem_req_rdy), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rsp_vld_i(mem_rsp_vld), .mem_rdata_i(mem_rdata)
  );

  // Reference model: a queue of pending loads in program order.
  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic        lsign;
    int unsigned nbytes;
    logic [31:0] addr;
  } pend_t;

  pend_t pend[$];
  int    total = 0;
  int    bad   = 0;
  bit    err_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
  endfunction

  // Value a load should return: take nbytes starting at the byte offset, then
  // treat it as a signed or unsigned number of that width.
  function automatic logic [31:0] model_load(input pend_t p, input logic [31:0] rdata);
    logic [63:0] mask, raw;
    mask = (64'd1 << (8 * p.nbytes)) - 64'd1;
    raw  = ({32'd0, rdata} >> (8 * (p.addr % 4))) & mask;
    if (p.lsign && p.nbytes < 4 && raw > (mask >> 1)) raw = raw - (mask + 64'd1);
    return raw[31:0];
  endfunction

  // One clock cycle: drive, check the combinational request side, clock, then
  // check the registered writeback side against the model.
  task automatic cycle(input logic vld, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic wen,
                       input logic lsign, input logic mrdy, input logic rsp,
                       input logic [31:0] rdata);
    bit          is_mem, st, mis, e_rdy, e_mvld, acc, e_wb, e_mis;
    int unsigned nb, cnt;
    logic [31:0] e_data, e_strb, e_wdata, lo;
    logic [4:0]  e_rd;
    logic        e_wen;
    pend_t       p;
    req_vld = vld; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_rd_wen = wen; req_lsign = lsign; mem_req_rdy = mrdy; mem_rsp_vld = rsp;
    mem_rdata = rdata;
    #1;
    is_mem = op[3];
    st     = op[2];
    nb     = size_bytes(op[1:0]);
    mis    = is_mem && ((nb == 4 && addr % 4 != 0) || (nb == 2 && addr % 2 != 0));
    cnt    = pend.size();
    e_rdy  = !is_mem ? (cnt == 0) : mis ? 1'b1 : st ? mrdy : (mrdy && cnt < OUT);
    e_mvld = vld && is_mem && !mis && (st || cnt < OUT);
    check("req_rdy", {31'd0, req_rdy}, {31'd0, e_rdy});
    check("mem_req_vld", {31'd0, mem_req_vld}, {31'd0, e_mvld});
    if (e_mvld) begin
      check("mem_addr", mem_addr, addr & ~32'd3);
      e_strb = st ? (((32'd1 << nb) - 32'd1) << (addr % 4)) : 32'd0;
      check("mem_we", {28'd0, mem_we}, e_strb);
      if (st) begin
        lo = (nb == 4) ? wdata : (wdata & ((32'd1 << (8 * nb)) - 32'd1));
        e_wdata = 32'd0;
        for (int k = 0; k < 4 / nb; k++) e_wdata = e_wdata | (lo << (8 * nb * k));
        check("mem_wdata", mem_wdata, e_wdata);
      end
    end
    e_wb = 1'b0; e_rd = '0; e_wen = 1'b0; e_data = '0;
    if (rsp && cnt > 0) begin
      p = pend.pop_front();
      e_wb = 1'b1; e_rd = p.rd; e_wen = p.wen; e_data = model_load(p, rdata);
    end else if (rsp) begin
      err_model = 1'b1;
    end
    acc = vld && e_rdy;
    if (acc && !is_mem) begin
      e_wb = 1'b1; e_rd = rd; e_wen = wen; e_data = addr;
    end
    if (acc && is_mem && !st && !mis)
      pend.push_back('{rd: rd, wen: wen, lsign: lsign, nbytes: nb, addr: addr});
    e_mis = acc && mis;
    @(posedge clk);
    #1;
    check("wb_vld", {31'd0, wb_vld}, {31'd0, e_wb});
    check("wb_wen", {31'd0, wb_wen}, {31'd0, e_wen});
    if (e_wb) begin
      check("wb_rd", {27'd0, wb_rd}, {27'd0, e_rd});
      check("wb_data", wb_data, e_data);
    end
    check("misal_vld", {31'd0, misal_vld}, {31'd0, e_mis});
    if (e_mis) check("misal_addr", misal_addr, addr);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, err_model});
  endtask

  task automatic idle(input logic rsp, input logic [31:0] rdata);
    cycle(1'b0, ALU, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, rsp, rdata);
  endtask

  initial begin
    req_vld = 0; req_op = ALU; req_addr = 0; req_wdata = 0; req_rd = 0; req_rd_wen = 0;
    req_lsign = 0; mem_req_rdy = 1; mem_rsp_vld = 0; mem_rdata = 0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_wb_vld", {31'd0, wb_vld}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_misal_vld", {31'd0, misal_vld}, 32'd0);
    check("rst_misal_addr", misal_addr, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // LW 0x100, response next cycle
    cycle(1, LW, 32'h100, 0, 5'd3, 1, 0, 1, 0, 0);
    idle(1'b1, 32'hDEADBEEF);
    check("lw_data", wb_data, 32'hDEADBEEF);

    // LB signed / unsigned at 0x103
    cycle(1, LB, 32'h103, 0, 5'd4, 1, 1, 1, 0, 0);
    idle(1'b1, 32'h80000000);
    check("lb_data", wb_data, 32'hFFFFFF80);
    cycle(1, LB, 32'h103, 0, 5'd5, 1, 0, 1, 0, 0);
    idle(1'b1, 32'h80000000);
    check("lbu_data", wb_data, 32'h00000080);

    // LH signed at upper half
    cycle(1, LH, 32'h206, 0, 5'd6, 1, 1, 1, 0, 0);
    idle(1'b1, 32'h8001_7FFF);

    // SH 0x102
    cycle(1, SH, 32'h102, 32'h1234, 5'd7, 1, 0, 1, 0, 0);
    check("sh_we", {28'd0, mem_we}, 32'h0000000C);
    check("sh_wdata", mem_wdata, 32'h12341234);
    check("sh_no_wb", {31'd0, wb_vld}, 32'd0);

    // Store stalled by memory, then accepted
    cycle(1, SW, 32'h300, 32'hCAFEF00D, 5'd1, 0, 0, 0, 0, 0);
    cycle(1, SW, 32'h300, 32'hCAFEF00D, 5'd1, 0, 0, 1, 0, 0);

    // Three back-to-back LW with no response: the third is held
    cycle(1, LW, 32'h400, 0, 5'd8, 1, 0, 1, 0, 0);
    cycle(1, LW, 32'h404, 0, 5'd9, 1, 0, 1, 0, 0);
    cycle(1, LW, 32'h408, 0, 5'd10, 1, 0, 1, 0, 0);
    check("third_held", {31'd0, req_rdy}, 32'd0);
    cycle(1, LW, 32'h408, 0, 5'd10, 1, 0, 1, 1, 32'h11111111);
    cycle(1, LW, 32'h408, 0, 5'd10, 1, 0, 1, 0, 0);
    // Non-mem op waits for the tracker to drain
    cycle(1, ALU, 32'h55, 0, 5'd11, 1, 0, 1, 1, 32'h22222222);
    cycle(1, ALU, 32'h55, 0, 5'd11, 1, 0, 1, 1, 32'h33333333);
    cycle(1, ALU, 32'h55, 0, 5'd11, 1, 0, 1, 0, 0);
    check("alu_data", wb_data, 32'h55);

    // Misaligned LW
    cycle(1, LW, 32'h101, 0, 5'd12, 1, 0, 1, 0, 0);
    check("misal_pulse", {31'd0, misal_vld}, 32'd1);
    check("misal_addr_dir", misal_addr, 32'h101);
    idle(1'b0, 0);

    // Reset with loads in flight
    cycle(1, LW, 32'h500, 0, 5'd13, 1, 0, 1, 0, 0);
    cycle(1, LW, 32'h504, 0, 5'd14, 1, 0, 1, 0, 0);
    idle(1'b1, 32'h55AA55AA);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_wb_vld", {31'd0, wb_vld}, 32'd0);
    check("mid_rst_wb_data", wb_data, 32'd0);
    check("mid_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
    pend.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1'b1, 32'h12345678);
    check("late_rsp_err", {31'd0, rsp_err}, 32'd1);
    idle(1'b0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned k, sz;
      logic [31:0] a;
      logic [3:0]  op;
      logic        v;
      k  = $urandom_range(0, 9);
      sz = $urandom_range(1, 3);
      a  = $urandom;
      v  = 1'b1;
      case (k)
        0, 1:    op = ALU;
        2, 3, 4: begin op = {2'b10, sz[1:0]}; a = a & ~((32'd1 << (sz - 1)) - 32'd1); end
        5, 6:    begin op = {2'b11, sz[1:0]}; a = a & ~((32'd1 << (sz - 1)) - 32'd1); end
        7:       begin op = {1'b1, 1'($urandom_range(0, 1)), 2'b11}; a = a | 32'd1; end
        default: begin op = 4'($urandom); v = 1'b0; end
      endcase
      cycle(v, op, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, pend.size() > 0 && $urandom_range(0, 2) != 0, $urandom);
    end
    while (pend.size() > 0) idle(1'b1, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
